// File: rtl/uart_rx_buffered_pkg.sv
// Shared types and helpers for the buffered UART receiver.
// Contents:
//   rx_state_e   one-hot receiver FSM states
//   parity_e     parity mode codes (NONE=0, ODD=1, EVEN=2)
//   calc_div     clock-per-tick divider, rounded, never below 1
package uart_rx_buffered_pkg;

    typedef enum logic [5:0] {
        ST_IDLE     = 6'b000001,
        ST_START    = 6'b000010,
        ST_DATA     = 6'b000100,
        ST_PARITY   = 6'b001000,
        ST_STOP     = 6'b010000,
        ST_BRK_WAIT = 6'b100000
    } rx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    // Round-to-nearest clocks per oversample tick.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned os);
        int unsigned den;
        int unsigned d;
        den = baud * os;
        d   = (clk_hz + den / 2) / den;
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_buffered_if.sv
// Read-side handshake bundle of the buffered UART receiver.
// Signals:
//   rx_data        head-of-FIFO data word
//   rx_parity_err  head word failed parity
//   rx_frame_err   head word had a 0 in a stop-bit position
//   rx_valid       FIFO not empty
//   rx_ready       consumer accepts the head word
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_buffered_if #(
    parameter int unsigned FRAME_WD = 8
) ();
    logic [FRAME_WD-1:0] rx_data;
    logic                rx_parity_err;
    logic                rx_frame_err;
    logic                rx_valid;
    logic                rx_ready;

    modport master (
        output rx_data,
        output rx_parity_err,
        output rx_frame_err,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_parity_err,
        input  rx_frame_err,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_buffered_fifo.sv
// Generic synchronous show-ahead FIFO with registered head word.
// Ports:
//   clk, reset_p  clock, asynchronous active-high reset
//   push          write push_data (ignored when full unless popping too)
//   push_data     word to store
//   pop           remove head word (ignored when empty)
//   head_data     current head word, 0 when empty
//   valid         FIFO holds at least one word
//   full_c        FIFO holds DEPTH words
//   count         words held
module uart_rx_buffered_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_p,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       valid,
    output logic                       full_c,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next_c;
    logic [CW-1:0]    count_next_c;
    logic [CW-1:0]    remaining_c;
    logic             do_push_c;
    logic             do_pop_c;

    // Push into a full FIFO is allowed only when the head leaves in the same cycle.
    always_comb begin
        full_c       = (count == CW'(DEPTH));
        do_pop_c     = pop && (count != '0);
        do_push_c    = push && (!full_c || do_pop_c);
        rd_next_c    = do_pop_c ? rd_ptr + AW'(1) : rd_ptr;
        remaining_c  = count - CW'(do_pop_c);
        count_next_c = remaining_c + CW'(do_push_c);
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, count and the registered head word.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid     <= 1'b0;
            head_data <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next_c;
            count  <= count_next_c;
            valid  <= (count_next_c != '0);
            // Bypass the array when the pushed word becomes the new head.
            if (count_next_c == '0) begin
                head_data <= '0;
            end else if (remaining_c == '0) begin
                head_data <= push_data;
            end else begin
                head_data <= mem[rd_next_c];
            end
        end
    end
endmodule

// File: rtl/uart_rx_buffered.sv
// Oversampling UART receiver with majority-vote sampling, false-start
// rejection, break detection, per-word error flags and a show-ahead RX FIFO.
// Ports:
//   clk, reset_p   clock, asynchronous active-high reset
//   uart_rx        serial line, idle high, asynchronous to clk
//   rx_if          master side of the read handshake (data, flags, valid/ready)
//   rx_break       1-clk pulse when a break is detected
//   overrun        sticky; a word was dropped because the FIFO was full
//   clr_err        synchronous clear of overrun
//   fifo_count     words held in the FIFO
module uart_rx_buffered
    import uart_rx_buffered_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCE = 125_000_000,
    parameter int unsigned BAUD_RATE     = 9600,
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned FRAME_WD      = 8,
    parameter string       PARITY        = "NONE",
    parameter int unsigned STOP_BITS     = 1,
    parameter int unsigned FIFO_DEPTH    = 16
) (
    input  logic                        clk,
    input  logic                        reset_p,
    input  logic                        uart_rx,
    uart_rx_buffered_if.master          rx_if,
    output logic                        rx_break,
    output logic                        overrun,
    input  logic                        clr_err,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned DIV    = calc_div(CLK_FREQUENCE, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SC_W   = $clog2(OVERSAMPLE);
    localparam int unsigned BI_W   = $clog2(FRAME_WD);
    localparam int unsigned WORD_W = FRAME_WD + 2;
    localparam int unsigned H_LO   = OVERSAMPLE / 2 - 1;
    localparam int unsigned H_MID  = OVERSAMPLE / 2;
    localparam int unsigned H_HI   = OVERSAMPLE / 2 + 1;

    localparam parity_e PAR_MODE = (PARITY == "ODD")  ? PAR_ODD  :
                                   (PARITY == "EVEN") ? PAR_EVEN : PAR_NONE;
    localparam bit HAS_PAR = (PAR_MODE != PAR_NONE);
    localparam bit IS_ODD  = (PAR_MODE == PAR_ODD);

    rx_state_e            state;
    logic [1:0]           sync_q;
    logic                 line;
    logic                 line_prev;
    logic [DIV_W-1:0]     div_cnt;
    logic [SC_W-1:0]      samp_cnt;
    logic [1:0]           vote;
    logic [BI_W-1:0]      bit_idx;
    logic                 stop_idx;
    logic [FRAME_WD-1:0]  data_sr;
    logic                 par_bit;
    logic                 par_err;
    logic                 frm_err;
    logic                 first_stop;
    logic                 push;
    logic [WORD_W-1:0]    push_word;
    logic [WORD_W-1:0]    head;
    logic                 fifo_full;

    logic tick_c;
    logic start_edge_c;
    logic decide_c;
    logic maj_c;
    logic first_stop_c;
    logic frame_err_c;
    logic is_break_c;
    logic pop_c;
    logic drop_c;

    // Two-flop line synchroniser plus a delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            sync_q    <= 2'b11;
            line_prev <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], uart_rx};
            line_prev <= sync_q[1];
        end
    end

    assign line = sync_q[1];

    always_comb begin
        tick_c       = (div_cnt == DIV_W'(DIV - 1));
        start_edge_c = (state == ST_IDLE) && line_prev && !line;
        decide_c     = tick_c && (samp_cnt == SC_W'(H_HI));
        maj_c        = (vote[0] & vote[1]) | (vote[0] & line) | (vote[1] & line);
        first_stop_c = (stop_idx == 1'b0) ? maj_c : first_stop;
        frame_err_c  = frm_err | ~maj_c;
        is_break_c   = (data_sr == '0) && !par_bit && !first_stop_c;
        pop_c        = rx_if.rx_valid & rx_if.rx_ready;
        drop_c       = push && fifo_full && !pop_c;
    end

    // Oversample tick divider; realigned to the start edge.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            div_cnt <= '0;
        end else if (start_edge_c || tick_c) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Receiver FSM: sample counting, bit decisions and word assembly.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state      <= ST_IDLE;
            samp_cnt   <= '0;
            vote       <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            data_sr    <= '0;
            par_bit    <= 1'b0;
            par_err    <= 1'b0;
            frm_err    <= 1'b0;
            first_stop <= 1'b0;
            push       <= 1'b0;
            push_word  <= '0;
            rx_break   <= 1'b0;
        end else begin
            push     <= 1'b0;
            rx_break <= 1'b0;

            if (tick_c && (state != ST_IDLE) && (state != ST_BRK_WAIT)) begin
                samp_cnt <= (samp_cnt == SC_W'(OVERSAMPLE - 1)) ? '0 : samp_cnt + SC_W'(1);
                if (samp_cnt == SC_W'(H_LO)) begin
                    vote[0] <= line;
                end
                if (samp_cnt == SC_W'(H_MID)) begin
                    vote[1] <= line;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start_edge_c) begin
                        state    <= ST_START;
                        samp_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (decide_c) begin
                        if (maj_c) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                            par_bit <= 1'b0;
                            par_err <= 1'b0;
                            frm_err <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (decide_c) begin
                        data_sr <= {maj_c, data_sr[FRAME_WD-1:1]};
                        if (bit_idx == BI_W'(FRAME_WD - 1)) begin
                            state    <= HAS_PAR ? ST_PARITY : ST_STOP;
                            stop_idx <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + BI_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (decide_c) begin
                        par_bit  <= maj_c;
                        par_err  <= (^data_sr) ^ maj_c ^ IS_ODD;
                        state    <= ST_STOP;
                        stop_idx <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (decide_c) begin
                        first_stop <= first_stop_c;
                        frm_err    <= frame_err_c;
                        if (stop_idx == 1'(STOP_BITS - 1)) begin
                            if (is_break_c) begin
                                rx_break <= 1'b1;
                                state    <= ST_BRK_WAIT;
                                samp_cnt <= '0;
                            end else begin
                                push      <= 1'b1;
                                push_word <= {frame_err_c, par_err, data_sr};
                                state     <= ST_IDLE;
                            end
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                ST_BRK_WAIT: begin
                    // Need one uninterrupted bit time of idle before re-arming.
                    if (!line) begin
                        samp_cnt <= '0;
                    end else if (tick_c) begin
                        if (samp_cnt == SC_W'(OVERSAMPLE - 1)) begin
                            state    <= ST_IDLE;
                            samp_cnt <= '0;
                        end else begin
                            samp_cnt <= samp_cnt + SC_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overrun; a fresh drop wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            overrun <= 1'b0;
        end else if (drop_c) begin
            overrun <= 1'b1;
        end else if (clr_err) begin
            overrun <= 1'b0;
        end
    end

    uart_rx_buffered_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_p   (reset_p),
        .push      (push),
        .push_data (push_word),
        .pop       (pop_c),
        .head_data (head),
        .valid     (rx_if.rx_valid),
        .full_c    (fifo_full),
        .count     (fifo_count)
    );

    assign rx_if.rx_data       = head[FRAME_WD-1:0];
    assign rx_if.rx_parity_err = head[FRAME_WD];
    assign rx_if.rx_frame_err  = head[FRAME_WD+1];
endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered: three receivers (8N1 depth 4, 8E2 depth 16,
// 8O1 depth 16) at 16 clk per bit, checked against a frame-level model.
module tb_uart_rx_buffered;

    logic       clk = 1'b0;
    logic       reset_p;
    logic [2:0] line;
    logic [2:0] clr;
    logic       brk0, brk1, brk2;
    logic       ovr0, ovr1, ovr2;
    logic [2:0] cnt0;
    logic [4:0] cnt1, cnt2;

    int n_cmp = 0;
    int n_bad = 0;
    int brk_seen0 = 0, brk_seen1 = 0, brk_seen2 = 0;

    // Per-receiver configuration as seen by the model.
    int cfg_depth [3] = '{4, 16, 16};
    int cfg_par   [3] = '{0, 1, 1};
    int cfg_odd   [3] = '{0, 0, 1};
    int cfg_nstop [3] = '{1, 2, 1};
    int exp_brk   [3] = '{0, 0, 0};
    int exp_ovr   [3] = '{0, 0, 0};

    logic [9:0] q0 [$];
    logic [9:0] q1 [$];
    logic [9:0] q2 [$];

    always #5 clk = ~clk;

    uart_rx_buffered_if #(.FRAME_WD(8)) if0 ();
    uart_rx_buffered_if #(.FRAME_WD(8)) if1 ();
    uart_rx_buffered_if #(.FRAME_WD(8)) if2 ();

    uart_rx_buffered #(
        .CLK_FREQUENCE(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
        .FRAME_WD(8), .PARITY("NONE"), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut0 (
        .clk(clk), .reset_p(reset_p), .uart_rx(line[0]), .rx_if(if0),
        .rx_break(brk0), .overrun(ovr0), .clr_err(clr[0]), .fifo_count(cnt0)
    );

    uart_rx_buffered #(
        .CLK_FREQUENCE(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
        .FRAME_WD(8), .PARITY("EVEN"), .STOP_BITS(2), .FIFO_DEPTH(16)
    ) dut1 (
        .clk(clk), .reset_p(reset_p), .uart_rx(line[1]), .rx_if(if1),
        .rx_break(brk1), .overrun(ovr1), .clr_err(clr[1]), .fifo_count(cnt1)
    );

    uart_rx_buffered #(
        .CLK_FREQUENCE(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
        .FRAME_WD(8), .PARITY("ODD"), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) dut2 (
        .clk(clk), .reset_p(reset_p), .uart_rx(line[2]), .rx_if(if2),
        .rx_break(brk2), .overrun(ovr2), .clr_err(clr[2]), .fifo_count(cnt2)
    );

    always @(negedge clk) begin
        if (brk0) brk_seen0++;
        if (brk1) brk_seen1++;
        if (brk2) brk_seen2++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] dut_head(input int sel);
        case (sel)
            0:       return {if0.rx_frame_err, if0.rx_parity_err, if0.rx_data};
            1:       return {if1.rx_frame_err, if1.rx_parity_err, if1.rx_data};
            default: return {if2.rx_frame_err, if2.rx_parity_err, if2.rx_data};
        endcase
    endfunction

    function automatic int dut_count(input int sel);
        case (sel)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    function automatic logic dut_valid(input int sel);
        case (sel)
            0:       return if0.rx_valid;
            1:       return if1.rx_valid;
            default: return if2.rx_valid;
        endcase
    endfunction

    function automatic logic dut_ovr(input int sel);
        case (sel)
            0:       return ovr0;
            1:       return ovr1;
            default: return ovr2;
        endcase
    endfunction

    function automatic int dut_brk(input int sel);
        case (sel)
            0:       return brk_seen0;
            1:       return brk_seen1;
            default: return brk_seen2;
        endcase
    endfunction

    function automatic int m_size(input int sel);
        case (sel)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [9:0] m_front(input int sel);
        case (sel)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic m_push(input int sel, input logic [9:0] w);
        case (sel)
            0:       q0.push_back(w);
            1:       q1.push_back(w);
            default: q2.push_back(w);
        endcase
    endtask

    task automatic m_pop(input int sel);
        logic [9:0] w;
        case (sel)
            0:       w = q0.pop_front();
            1:       w = q1.pop_front();
            default: w = q2.pop_front();
        endcase
    endtask

    // Frame-level model: error flags, break recognition and FIFO capacity.
    task automatic model_rx(input int sel, input logic [7:0] d, input logic pbit,
                            input logic [1:0] stops);
        logic pe, fe, brk;
        pe  = (cfg_par[sel] != 0) ? ((^d) ^ pbit ^ (cfg_odd[sel] != 0)) : 1'b0;
        fe  = !stops[0] || (cfg_nstop[sel] == 2 && !stops[1]);
        brk = (d == 8'h00) && (cfg_par[sel] == 0 || !pbit) && !stops[0];
        if (brk)
            exp_brk[sel]++;
        else if (m_size(sel) >= cfg_depth[sel])
            exp_ovr[sel] = 1;
        else
            m_push(sel, {fe, pe, d});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame on the selected line, 16 clk per bit, ending idle high.
    task automatic drive_frame(input int sel, input logic [7:0] d, input logic pbit,
                               input logic [1:0] stops);
        logic bits [$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (cfg_par[sel] != 0) bits.push_back(pbit);
        bits.push_back(stops[0]);
        if (cfg_nstop[sel] == 2) bits.push_back(stops[1]);
        foreach (bits[i]) begin
            line[sel] = bits[i];
            idle(16);
        end
        line[sel] = 1'b1;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic pbit,
                              input logic [1:0] stops);
        drive_frame(sel, d, pbit, stops);
        model_rx(sel, d, pbit, stops);
        idle(32);
    endtask

    task automatic check_head(input int sel, input string tag);
        check({tag, "_count"}, 32'(dut_count(sel)), 32'(m_size(sel)));
        check({tag, "_valid"}, 32'(dut_valid(sel)), 32'(m_size(sel) != 0));
        if (m_size(sel) != 0)
            check({tag, "_word"}, 32'(dut_head(sel)), 32'(m_front(sel)));
    endtask

    task automatic pop_word(input int sel, input string tag);
        check_head(sel, tag);
        case (sel)
            0:       if0.rx_ready = 1'b1;
            1:       if1.rx_ready = 1'b1;
            default: if2.rx_ready = 1'b1;
        endcase
        idle(1);
        if0.rx_ready = 1'b0;
        if1.rx_ready = 1'b0;
        if2.rx_ready = 1'b0;
        if (m_size(sel) != 0) m_pop(sel);
    endtask

    // One-cycle pulse on receiver 0's rx_ready (kind 0) or clr_err (kind 1).
    task automatic pulse_at(input int cyc, input int kind);
        repeat (cyc) @(posedge clk);
        #1;
        if (kind == 0) if0.rx_ready = 1'b1; else clr[0] = 1'b1;
        idle(1);
        if0.rx_ready = 1'b0;
        clr[0] = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic       pb;
        logic [1:0] st;

        reset_p = 1'b1;
        line    = 3'b111;
        clr     = 3'b000;
        if0.rx_ready = 1'b0;
        if1.rx_ready = 1'b0;
        if2.rx_ready = 1'b0;
        idle(3);
        for (int s = 0; s < 3; s++) begin
            check_head(s, "reset");
            check("reset_data", 32'(dut_head(s)), 32'h0);
            check("reset_ovr", 32'(dut_ovr(s)), 32'h0);
        end
        reset_p = 1'b0;
        idle(5);

        // 8N1 0xA5
        send_frame(0, 8'hA5, 1'b0, 2'b11);
        check("a5_count", 32'(dut_count(0)), 32'd1);
        pop_word(0, "a5");
        check_head(0, "a5_after_pop");

        // Even parity, wrong parity bit; odd parity, correct parity bit
        send_frame(1, 8'h3C, 1'b1, 2'b11);
        check("even_perr", 32'(if1.rx_parity_err), 32'd1);
        pop_word(1, "even3c");
        send_frame(2, 8'h3C, 1'b1, 2'b11);
        check("odd_perr", 32'(if2.rx_parity_err), 32'd0);
        pop_word(2, "odd3c");

        // 4-clk low glitch on idle line
        line[0] = 1'b0;
        idle(4);
        line[0] = 1'b1;
        idle(40);
        check_head(0, "glitch");
        check("glitch_brk", 32'(dut_brk(0)), 32'(exp_brk[0]));

        // Second stop bit low
        send_frame(1, 8'h55, 1'b0, 2'b01);
        check("stop2_ferr", 32'(if1.rx_frame_err), 32'd1);
        pop_word(1, "stop2");

        // Break: 20 bit times low, then idle, then a normal frame
        line[0] = 1'b0;
        idle(320);
        line[0] = 1'b1;
        exp_brk[0]++;
        idle(32);
        check("break_pulses", 32'(dut_brk(0)), 32'(exp_brk[0]));
        check_head(0, "break_empty");
        send_frame(0, 8'h12, 1'b0, 2'b11);
        pop_word(0, "after_break");

        // Randomized frames on every receiver
        for (int i = 0; i < 8; i++) begin
            for (int s = 0; s < 3; s++) begin
                d  = (i == 0) ? 8'h00 : 8'($urandom_range(0, 255));
                pb = 1'($urandom_range(0, 1));
                st = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
                send_frame(s, d, pb, st);
                check_head(s, "rand");
                check("rand_brk", 32'(dut_brk(s)), 32'(exp_brk[s]));
                while (m_size(s) != 0) pop_word(s, "rand_pop");
            end
        end

        // Overrun: five frames into a depth-4 FIFO
        for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 2'b11);
        check("ovr_count", 32'(cnt0), 32'd4);
        check("ovr_set", 32'(ovr0), 32'(exp_ovr[0]));
        for (int i = 1; i <= 4; i++) begin
            check("ovr_drain", 32'(if0.rx_data), 32'(i));
            pop_word(0, "ovr_drain");
        end
        check("ovr_sticky", 32'(ovr0), 32'd1);
        clr[0] = 1'b1;
        idle(1);
        clr[0] = 1'b0;
        exp_ovr[0] = 0;
        check("ovr_clr", 32'(ovr0), 32'(exp_ovr[0]));

        // clr_err on the same edge as a dropped push: overrun stays set.
        // Last stop decision lands 157 clk into a 10-bit frame, push one edge later.
        for (int i = 1; i <= 4; i++) send_frame(0, 8'(8'h10 + i), 1'b0, 2'b11);
        fork
            drive_frame(0, 8'hA0, 1'b0, 2'b11);
            pulse_at(157, 1);
        join
        model_rx(0, 8'hA0, 1'b0, 2'b11);
        idle(32);
        check("clr_vs_drop", 32'(ovr0), 32'(exp_ovr[0]));
        clr[0] = 1'b1;
        idle(1);
        clr[0] = 1'b0;
        exp_ovr[0] = 0;
        check("clr_again", 32'(ovr0), 32'd0);
        while (m_size(0) != 0) pop_word(0, "clr_drain");

        // Pop on the same edge as the push into a full FIFO
        for (int i = 1; i <= 4; i++) send_frame(0, 8'(i), 1'b0, 2'b11);
        fork
            drive_frame(0, 8'h05, 1'b0, 2'b11);
            pulse_at(157, 0);
        join
        m_pop(0);
        m_push(0, {2'b00, 8'h05});
        idle(32);
        check("pp_ovr", 32'(ovr0), 32'd0);
        check("pp_count", 32'(cnt0), 32'd4);
        for (int i = 2; i <= 5; i++) begin
            check("pp_drain", 32'(if0.rx_data), 32'(i));
            pop_word(0, "pp_drain");
        end

        // Reset in the middle of a frame with words already queued
        send_frame(0, 8'h33, 1'b0, 2'b11);
        send_frame(1, 8'h44, 1'b0, 2'b11);
        line[0] = 1'b0;
        idle(64);
        reset_p = 1'b1;
        line[0] = 1'b1;
        q0.delete();
        q1.delete();
        q2.delete();
        exp_ovr = '{0, 0, 0};
        idle(3);
        check_head(0, "mid_reset0");
        check_head(1, "mid_reset1");
        check("mid_reset_data", 32'(dut_head(0)), 32'h0);
        reset_p = 1'b0;
        idle(40);
        check_head(0, "post_reset");
        check("post_reset_brk", 32'(dut_brk(0)), 32'(exp_brk[0]));
        send_frame(0, 8'h7E, 1'b0, 2'b11);
        check("rst_7e", 32'(if0.rx_data), 32'h7E);
        pop_word(0, "rst_7e");

        for (int s = 0; s < 3; s++) begin
            check("final_brk", 32'(dut_brk(s)), 32'(exp_brk[s]));
            check("final_ovr", 32'(dut_ovr(s)), 32'(exp_ovr[s]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
